if_id_buffer: RTL and testbench
===============================

# if_id_buffer

Fetch-to-decode pipeline buffer. It sits directly downstream of the fetch stage and captures each fetched instruction together with its instruction address and PC+4. It presents them to the decode stage through a valid/ready handshake, with a 2-entry skid so fetch backpressure is fully registered. A synchronous flush discards all held instructions when the pipeline redirects on a taken branch.

## Interface
- `XLEN`, 32: width of PC and instruction fields.
- `NOP_INST`, 32'h00000013: instruction driven on `out_inst` when no valid entry is presented (`addi x0,x0,0`).

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `flush`  in  1  synchronous discard of all entries (taken branch or redirect).
- `in_valid`  in  1  fetch presents a fetched instruction this cycle.
- `in_ready`  out  1  buffer accepts an entry this cycle.
- `in_pc`  in  XLEN  instruction address from fetch.
- `in_pc4`  in  XLEN  PC+4 from fetch.
- `in_inst`  in  XLEN  instruction word from instruction memory.
- `out_valid`  out  1  decode-side entry valid.
- `out_ready`  in  1  decode consumes the entry this cycle.
- `out_pc`, `out_pc4`, `out_inst`  out  XLEN  held entry fields.

## Operation
- Accept: `in_valid && in_ready`. Dequeue: `out_valid && out_ready`.
- Storage: main register (drives outputs) plus skid register.
- States:
  - EMPTY: nothing held.
  - ONE: main register valid.
  - FULL: main and skid registers valid.
- Transitions (no flush):
  - EMPTY, accept -> ONE; the entry is written to main.
  - ONE, accept and no dequeue -> FULL; the entry is written to skid.
  - ONE, accept and dequeue -> ONE; main is overwritten with the new entry.
  - ONE, dequeue only -> EMPTY.
  - FULL, dequeue -> ONE; skid moves to main. Accept cannot occur in FULL.
  - Any other combination holds the current state.
- `in_ready` is registered. It is 1 in EMPTY/ONE and 0 in FULL. It is computed from the next state, so it is valid in the cycle after each transition.
- `out_valid` is 1 in ONE and FULL.
- When `out_valid`=0:
  - `out_inst` = `NOP_INST`.
  - `out_pc` and `out_pc4` = 0.
- `flush` has the highest priority:
  - Next state is EMPTY.
  - An accept in the same cycle is discarded.
  - A dequeue in the same cycle still counts as consumed by decode.
  - `in_ready` = 1 the following cycle.
- Entries are delivered strictly in accept order. No field is modified by the buffer.

## Timing
- Reset (asynchronous, `reset`=0): state EMPTY, `out_valid`=0, `in_ready`=1, `out_pc`=0, `out_pc4`=0, `out_inst`=`NOP_INST`, skid cleared.
- Latency: an entry accepted in cycle N is on the outputs with `out_valid`=1 in cycle N+1.
- Throughput: one entry per cycle while `out_ready`=1.
- Decode stall with continuous fetch: the buffer holds 2 entries. `in_ready` drops in the cycle after the second accept, with no combinational path from `out_ready` to `in_ready`.
- Reset asserted mid-operation: all entries are lost immediately, with outputs at their reset values.
- `in_*` inputs are sampled only on accept. `out_*` outputs are stable while `out_valid && !out_ready`.

## Configuration
- `IF_ID_SKID_EN` defined:
  - 2-entry skid behaviour as described above.
  - `in_ready` is registered.
- Not defined:
  - Single main register only; FULL state is absent.
  - `in_ready` = `out_ready || !out_valid`, combinational.
  - Accept and dequeue in ONE overwrites main.
  - Flush, reset and NOP rules are unchanged.

## Test plan
- Reset then stream: release `reset`, drive pc 0x00,0x04,0x08 with insts 0x00500093, 0x00108113, 0x002081B3, `out_ready`=1 -> outputs show the same sequence one cycle later with `out_pc4` 0x04,0x08,0x0C, and `in_ready` stays 1.
- Decode stall: `out_ready`=0 while fetching pc 0x10, 0x14, 0x18 -> 0x10 and 0x14 are accepted, `in_ready`=0 before 0x18. Release `out_ready` -> 0x10, 0x14, 0x18 are delivered in order with no loss or duplicate.
- Flush while FULL: entries 0x20 and 0x24 are held, and `flush`=1 with `in_valid` pc 0x28 -> next cycle `out_valid`=0, `out_inst`=0x00000013, `in_ready`=1, and 0x28 is never output.
- Simultaneous accept and dequeue in ONE, for 10 cycles -> one entry out per cycle and the state remains ONE.
- Asynchronous reset mid-stall while FULL -> `out_valid` and `out_pc` drop to 0 without waiting for a clock edge, and `in_ready`=1 after release.
- Build without `IF_ID_SKID_EN`: stall test -> `in_ready` falls in the same cycle that `out_ready`=0 while `out_valid`=1, and there is no data loss.

Source files
------------

// File: rtl/if_id_buffer.sv
// -----------------------------------------------------------------------------
// if_id_buffer
//
// Fetch-to-decode pipeline buffer. It captures each fetched instruction with
// its address and PC+4, and hands them to decode over a valid/ready
// handshake. Entries leave in the order they were accepted and are never
// modified. A synchronous flush drops everything held, for example when a
// taken branch redirects fetch.
//
// Build option:
//   IF_ID_SKID_EN  defined     : main register plus one skid register. Up to
//                                two entries are held, and in_ready is a
//                                register, so there is no combinational path
//                                from out_ready to in_ready.
//                  not defined : main register only.
//                                in_ready = out_ready || !out_valid
//                                (combinational).
//
// Parameters:
//   XLEN      width of the pc, pc4 and instruction fields
//   NOP_INST  instruction presented on out_inst while nothing is valid
//
// Ports:
//   clk        clock; all state changes on the rising edge
//   reset      asynchronous, active-low reset
//   flush      synchronous discard of every held entry
//   in_valid   fetch presents an instruction
//   in_ready   buffer can take an entry this cycle
//   in_pc      instruction address from fetch
//   in_pc4     PC+4 from fetch
//   in_inst    instruction word from instruction memory
//   out_valid  an entry is presented to decode
//   out_ready  decode consumes the presented entry this cycle
//   out_pc     presented pc       (0 when out_valid = 0)
//   out_pc4    presented pc+4     (0 when out_valid = 0)
//   out_inst   presented inst     (NOP_INST when out_valid = 0)
// -----------------------------------------------------------------------------
module if_id_buffer #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] NOP_INST = 32'h00000013
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_pc,
    input  logic [XLEN-1:0] in_pc4,
    input  logic [XLEN-1:0] in_inst,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_pc4,
    output logic [XLEN-1:0] out_inst
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t          state_reg;
    logic [XLEN-1:0] main_pc_reg;
    logic [XLEN-1:0] main_pc4_reg;
    logic [XLEN-1:0] main_inst_reg;
    logic            accept;
    logic            dequeue;

    assign out_valid = (state_reg != ST_EMPTY);
    assign accept    = in_valid && in_ready;
    assign dequeue   = out_valid && out_ready;

`ifdef IF_ID_SKID_EN
    logic            in_ready_reg;
    logic [XLEN-1:0] skid_pc_reg;
    logic [XLEN-1:0] skid_pc4_reg;
    logic [XLEN-1:0] skid_inst_reg;

    assign in_ready = in_ready_reg;
`else
    // Without a skid slot the buffer can take a new entry only when the
    // current one leaves in the same cycle or nothing is held.
    assign in_ready = out_ready || !out_valid;
`endif

    // Outputs are gated by out_valid. Stale register contents therefore never
    // reach decode, and an asynchronous reset forces the idle values at once,
    // without waiting for a clock edge.
    assign out_pc   = out_valid ? main_pc_reg   : '0;
    assign out_pc4  = out_valid ? main_pc4_reg  : '0;
    assign out_inst = out_valid ? main_inst_reg : NOP_INST;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg     <= ST_EMPTY;
            main_pc_reg   <= '0;
            main_pc4_reg  <= '0;
            main_inst_reg <= NOP_INST;
`ifdef IF_ID_SKID_EN
            in_ready_reg  <= 1'b1;
            skid_pc_reg   <= '0;
            skid_pc4_reg  <= '0;
            skid_inst_reg <= '0;
`endif
        end else if (flush) begin
            // A flush wins over everything. An accept in this cycle is
            // dropped. A dequeue in this cycle was already taken by decode,
            // so nothing more needs to be done for it.
            state_reg <= ST_EMPTY;
`ifdef IF_ID_SKID_EN
            in_ready_reg <= 1'b1;
`endif
        end else begin
            case (state_reg)
                ST_EMPTY: begin
                    if (accept) begin
                        main_pc_reg   <= in_pc;
                        main_pc4_reg  <= in_pc4;
                        main_inst_reg <= in_inst;
                        state_reg     <= ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (accept && dequeue) begin
                        // The old entry leaves as the new one arrives.
                        main_pc_reg   <= in_pc;
                        main_pc4_reg  <= in_pc4;
                        main_inst_reg <= in_inst;
`ifdef IF_ID_SKID_EN
                    end else if (accept) begin
                        // Decode is stalled, so the new entry goes to the skid
                        // slot. The buffer is now full, so ready is dropped
                        // for the next cycle.
                        skid_pc_reg   <= in_pc;
                        skid_pc4_reg  <= in_pc4;
                        skid_inst_reg <= in_inst;
                        state_reg     <= ST_FULL;
                        in_ready_reg  <= 1'b0;
`endif
                    end else if (dequeue) begin
                        state_reg <= ST_EMPTY;
                    end
                end
`ifdef IF_ID_SKID_EN
                ST_FULL: begin
                    // in_ready is 0 here, so the only event is a dequeue.
                    if (dequeue) begin
                        main_pc_reg   <= skid_pc_reg;
                        main_pc4_reg  <= skid_pc4_reg;
                        main_inst_reg <= skid_inst_reg;
                        state_reg     <= ST_ONE;
                        in_ready_reg  <= 1'b1;
                    end
                end
`endif
                default: begin
                    state_reg <= ST_EMPTY;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_if_id_buffer.sv
// -----------------------------------------------------------------------------
// tb_if_id_buffer
//
// Directed, table-driven bench for if_id_buffer, plus hand-written sequences
// for the stall, flush-while-holding and asynchronous-reset cases.
// Inputs are driven 1 time unit after the rising edge. Outputs are sampled on
// the falling edge.
// -----------------------------------------------------------------------------
module tb_if_id_buffer;

    localparam logic [31:0] NOP = 32'h00000013;

    logic        clk;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_pc;
    logic [31:0] in_pc4;
    logic [31:0] in_inst;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_pc4;
    logic [31:0] out_inst;

    int checks_total;
    int checks_passed;

    if_id_buffer #(
        .XLEN     (32),
        .NOP_INST (32'h00000013)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_pc     (in_pc),
        .in_pc4    (in_pc4),
        .in_inst   (in_inst),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_pc    (out_pc),
        .out_pc4   (out_pc4),
        .out_inst  (out_inst)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        iv;
        logic        ordy;
        logic        fl;
        logic [31:0] pc;
        logic [31:0] inst;
        logic        ev;
        logic        chk_rdy;
        logic        erdy;
        logic [31:0] epc;
        logic [31:0] einst;
    } vec_t;

    vec_t vecs[$];

    // Instruction word used for a given pc in the loop and stall sequences.
    function automatic logic [31:0] inst_of(input logic [31:0] pc);
        return 32'hA000_0000 ^ pc;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks_total++;
        if (act !== exp)
            $display("FAIL %s: actual %h required %h", name, act, exp);
        else
            checks_passed++;
    endtask

    task automatic drive(input logic iv, input logic ordy, input logic fl,
                         input logic [31:0] pc, input logic [31:0] inst);
        in_valid  = iv;
        out_ready = ordy;
        flush     = fl;
        in_pc     = pc;
        in_pc4    = pc + 32'd4;
        in_inst   = inst;
    endtask

    task automatic add(input logic iv, input logic ordy, input logic fl,
                       input logic [31:0] pc, input logic [31:0] inst,
                       input logic ev, input logic chk_rdy, input logic erdy,
                       input logic [31:0] epc, input logic [31:0] einst);
        vec_t v;
        v.iv = iv; v.ordy = ordy; v.fl = fl; v.pc = pc; v.inst = inst;
        v.ev = ev; v.chk_rdy = chk_rdy; v.erdy = erdy;
        v.epc = ev ? epc : 32'd0;
        v.einst = ev ? einst : NOP;
        vecs.push_back(v);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] pcs [3];
        int fi;
        int oi;
        int c;

        checks_total  = 0;
        checks_passed = 0;
        reset = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);

        // ---------------- vector table ----------------
        //   iv ordy fl  pc           inst          ev rdyck erdy epc        einst
        // Reset state.
        add(0, 1, 0, 32'h0,   32'h0,        0, 1, 1, 32'h0,  32'h0);
        // Stream of three instructions. Each appears one cycle after accept.
        add(1, 1, 0, 32'h00,  32'h00500093, 0, 1, 1, 32'h0,  32'h0);
        add(1, 1, 0, 32'h04,  32'h00108113, 1, 1, 1, 32'h00, 32'h00500093);
        add(1, 1, 0, 32'h08,  32'h002081B3, 1, 1, 1, 32'h04, 32'h00108113);
        add(0, 1, 0, 32'h0,   32'h0,        1, 1, 1, 32'h08, 32'h002081B3);
        add(0, 1, 0, 32'h0,   32'h0,        0, 1, 1, 32'h0,  32'h0);
        // Flush together with an accept and a dequeue: 0x40 is consumed and
        // 0x44 is dropped.
        add(1, 1, 0, 32'h40,  32'h11111111, 0, 1, 1, 32'h0,  32'h0);
        add(1, 1, 1, 32'h44,  32'h22222222, 1, 1, 1, 32'h40, 32'h11111111);
        add(0, 1, 0, 32'h0,   32'h0,        0, 1, 1, 32'h0,  32'h0);
        // Flush while decode is stalled. in_ready depends on the build, so it
        // is not checked in the flush cycle.
        add(1, 0, 0, 32'h50,  32'h33333333, 0, 1, 1, 32'h0,  32'h0);
        add(0, 0, 1, 32'h0,   32'h0,        1, 0, 0, 32'h50, 32'h33333333);
        add(0, 0, 0, 32'h0,   32'h0,        0, 1, 1, 32'h0,  32'h0);
        // Ten cycles of simultaneous accept and dequeue: one entry per cycle.
        add(1, 1, 0, 32'h100, inst_of(32'h100), 0, 1, 1, 32'h0, 32'h0);
        for (int k = 0; k < 10; k++) begin
            add(1, 1, 0, 32'h104 + 32'(4 * k), inst_of(32'h104 + 32'(4 * k)),
                1, 1, 1, 32'h100 + 32'(4 * k), inst_of(32'h100 + 32'(4 * k)));
        end
        add(0, 1, 0, 32'h0,   32'h0,        1, 1, 1, 32'h128, inst_of(32'h128));
        add(0, 1, 0, 32'h0,   32'h0,        0, 1, 1, 32'h0,  32'h0);

        repeat (2) @(posedge clk);
        #1 reset = 1'b1;

        foreach (vecs[i]) begin
            drive(vecs[i].iv, vecs[i].ordy, vecs[i].fl, vecs[i].pc, vecs[i].inst);
            @(negedge clk);
            $display("vec %0d: iv=%0d ordy=%0d fl=%0d pc=%h -> out_valid=%0d out_pc=%h out_inst=%h in_ready=%0d",
                     i, vecs[i].iv, vecs[i].ordy, vecs[i].fl, vecs[i].pc,
                     out_valid, out_pc, out_inst, in_ready);
            chk($sformatf("vec%0d out_valid", i), {31'd0, out_valid}, {31'd0, vecs[i].ev});
            chk($sformatf("vec%0d out_pc", i), out_pc, vecs[i].epc);
            chk($sformatf("vec%0d out_pc4", i), out_pc4,
                vecs[i].ev ? vecs[i].epc + 32'd4 : 32'd0);
            chk($sformatf("vec%0d out_inst", i), out_inst, vecs[i].einst);
            if (vecs[i].chk_rdy)
                chk($sformatf("vec%0d in_ready", i), {31'd0, in_ready}, {31'd0, vecs[i].erdy});
            next_cycle();
        end

        // ---------------- decode stall with continuous fetch ----------------
        pcs[0] = 32'h10; pcs[1] = 32'h14; pcs[2] = 32'h18;
        fi = 0;
        oi = 0;
        c  = 0;
        while (c < 30 && oi < 3) begin
            drive(fi < 3, c >= 4, 1'b0, pcs[(fi < 3) ? fi : 2], inst_of(pcs[(fi < 3) ? fi : 2]));
            @(negedge clk);
`ifdef IF_ID_SKID_EN
            if (c == 1) chk("stall second accept ready", {31'd0, in_ready}, 32'd1);
            if (c == 2) begin
                chk("stall in_ready low", {31'd0, in_ready}, 32'd0);
                chk("stall accepted count", 32'(fi), 32'd2);
            end
`else
            if (c == 1) begin
                chk("stall in_ready low", {31'd0, in_ready}, 32'd0);
                chk("stall out_valid", {31'd0, out_valid}, 32'd1);
                chk("stall accepted count", 32'(fi), 32'd1);
            end
`endif
            if (c == 3) chk("stall output held", out_pc, 32'h10);
            if (out_valid && out_ready) begin
                $display("stall cycle %0d: delivered pc=%h inst=%h", c, out_pc, out_inst);
                chk($sformatf("stall deliver%0d pc", oi), out_pc, pcs[oi]);
                chk($sformatf("stall deliver%0d pc4", oi), out_pc4, pcs[oi] + 32'd4);
                chk($sformatf("stall deliver%0d inst", oi), out_inst, inst_of(pcs[oi]));
                oi++;
            end
            if (in_valid && in_ready) fi++;
            next_cycle();
            c++;
        end
        chk("stall delivered count", 32'(oi), 32'd3);
        drive(1'b0, 1'b1, 1'b0, 32'd0, 32'd0);
        @(negedge clk);
        chk("stall no duplicate", {31'd0, out_valid}, 32'd0);
        next_cycle();

        // ---------------- flush while holding entries ----------------
        drive(1'b1, 1'b0, 1'b0, 32'h20, inst_of(32'h20));
        next_cycle();
        drive(1'b1, 1'b0, 1'b0, 32'h24, inst_of(32'h24));
        next_cycle();
        drive(1'b1, 1'b0, 1'b1, 32'h28, inst_of(32'h28));
        @(negedge clk);
        chk("flushfull in_ready before", {31'd0, in_ready}, 32'd0);
        chk("flushfull head pc", out_pc, 32'h20);
        next_cycle();
        drive(1'b0, 1'b1, 1'b0, 32'd0, 32'd0);
        @(negedge clk);
        $display("flush: out_valid=%0d out_inst=%h in_ready=%0d", out_valid, out_inst, in_ready);
        chk("flushfull out_valid", {31'd0, out_valid}, 32'd0);
        chk("flushfull out_inst", out_inst, NOP);
        chk("flushfull out_pc", out_pc, 32'd0);
        chk("flushfull in_ready", {31'd0, in_ready}, 32'd1);
        next_cycle();
        drive(1'b1, 1'b1, 1'b0, 32'h30, inst_of(32'h30));
        @(negedge clk);
        chk("flushfull still empty", {31'd0, out_valid}, 32'd0);
        next_cycle();
        drive(1'b0, 1'b1, 1'b0, 32'd0, 32'd0);
        @(negedge clk);
        chk("flushfull fresh pc", out_pc, 32'h30);
        chk("flushfull fresh inst", out_inst, inst_of(32'h30));
        next_cycle();
        @(negedge clk);
        chk("flushfull drained", {31'd0, out_valid}, 32'd0);
        next_cycle();

        // ---------------- asynchronous reset mid-stall ----------------
        drive(1'b1, 1'b0, 1'b0, 32'h60, inst_of(32'h60));
        next_cycle();
        drive(1'b1, 1'b0, 1'b0, 32'h64, inst_of(32'h64));
        next_cycle();
        drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        @(negedge clk);
        chk("areset held before", out_pc, 32'h60);
        #1 reset = 1'b0;
        #1;
        $display("async reset: out_valid=%0d out_pc=%h out_inst=%h", out_valid, out_pc, out_inst);
        chk("areset out_valid", {31'd0, out_valid}, 32'd0);
        chk("areset out_pc", out_pc, 32'd0);
        chk("areset out_pc4", out_pc4, 32'd0);
        chk("areset out_inst", out_inst, NOP);
        #1 reset = 1'b1;
        next_cycle();
        drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        @(negedge clk);
        chk("areset in_ready after", {31'd0, in_ready}, 32'd1);
        chk("areset stays empty", {31'd0, out_valid}, 32'd0);
        next_cycle();

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
